// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier sequencer.
package booth_pkg;

  localparam int BOOTH_WIDTH = 5;
  localparam int BOOTH_CNT_W = 3;

  // Adder operand select codes presented to the datapath mux.
  localparam logic [1:0] SEL_ADD_Y = 2'b00;
  localparam logic [1:0] SEL_SUB_Y = 2'b01;
  localparam logic [1:0] SEL_ZERO  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_Y = 3'd1,
    LOAD_X = 3'd2,
    ADD    = 3'd3,
    SHIFT  = 3'd4,
    OUT_HI = 3'd5,
    OUT_LO = 3'd6
  } booth_state_e;

  // Booth recoding of the current multiplier bit pair {x0, x(-1)}.
  // 10 starts a run of ones (subtract), 01 ends one (add), 00/11 add zero.
  function automatic logic [1:0] booth_sel(input logic x0, input logic xneg1);
    logic [1:0] sel;
    sel = SEL_ZERO;
    unique case ({x0, xneg1})
      2'b10:   sel = SEL_SUB_Y;
      2'b01:   sel = SEL_ADD_Y;
      default: sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth add/shift loop. Cleared while operands
// load, advanced once per shift; last flags the final iteration.
module booth_iter_counter #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic incr,
  output logic last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (incr) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register, asynchronously cleared by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_controller.sv
// Sequencing FSM for the radix-2 Booth multiplier datapath. Loads Y then X
// from the shared bus, runs WIDTH add-then-shift iterations, and steers the
// product onto the output bus high half first, then low half.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; all strobes low
//   LOAD_Y | capture multiplicand Y from inBus
//   LOAD_X | capture multiplier X, clear A and X(-1), reset iteration count
//   ADD    | A <= A + {+Y, -Y, 0} chosen by {x0, xneg1}
//   SHIFT  | arithmetic shift of A:X, X(-1) takes the bit shifted out
//   OUT_HI | outBus shows A (product high half)
//   OUT_LO | outBus shows X (product low half); done pulse
module booth_controller
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH,
  parameter int CNT_W = BOOTH_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       x0,
  input  logic       xneg1,
  output logic       LdY,
  output logic       LdX,
  output logic       ClrAX,
  output logic       LdA,
  output logic [1:0] selMux,
  output logic       shR,
  output logic       LdNegX,
  output logic       selOut,
  output logic       busy,
  output logic       done
);

  booth_state_e state_q;
  booth_state_e state_d;

  logic cnt_clr;
  logic cnt_inc;
  logic cnt_last;

  booth_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clr),
    .incr  (cnt_inc),
    .last  (cnt_last)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode; selMux in ADD is the only input-dependent output.
  always_comb begin
    state_d = state_q;
    LdY     = 1'b0;
    LdX     = 1'b0;
    ClrAX   = 1'b0;
    LdA     = 1'b0;
    selMux  = SEL_ZERO;
    shR     = 1'b0;
    LdNegX  = 1'b0;
    selOut  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = LOAD_Y;
        end
      end
      LOAD_Y: begin
        LdY     = 1'b1;
        state_d = LOAD_X;
      end
      LOAD_X: begin
        LdX     = 1'b1;
        ClrAX   = 1'b1;
        cnt_clr = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        // A is reloaded even for the add-zero case so the datapath needs no hold path.
        LdA     = 1'b1;
        selMux  = booth_sel(x0, xneg1);
        state_d = SHIFT;
      end
      SHIFT: begin
        shR     = 1'b1;
        LdNegX  = 1'b1;
        cnt_inc = 1'b1;
        state_d = cnt_last ? OUT_HI : ADD;
      end
      OUT_HI: begin
        selOut  = 1'b1;
        state_d = OUT_LO;
      end
      OUT_LO: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller with a behavioural Booth datapath beside it.
module tb_booth_controller;
  import booth_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       x0;
  logic       xneg1;
  logic       LdY, LdX, ClrAX, LdA, shR, LdNegX, selOut, busy, done;
  logic [1:0] selMux;

  booth_controller dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x0     (x0),
    .xneg1  (xneg1),
    .LdY    (LdY),
    .LdX    (LdX),
    .ClrAX  (ClrAX),
    .LdA    (LdA),
    .selMux (selMux),
    .shR    (shR),
    .LdNegX (LdNegX),
    .selOut (selOut),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: A carries a guard bit so -16 * -16 stays exact.
  logic [4:0]        y_cur, x_cur;
  logic [4:0]        inBus, outBus;
  logic [4:0]        y_q, x_q;
  logic signed [5:0] a_q;
  logic              xm1_q;
  logic signed [5:0] y_ext, operand;

  assign inBus  = LdY ? y_cur : (LdX ? x_cur : 5'd0);
  assign outBus = selOut ? a_q[4:0] : x_q;
  assign x0     = x_q[0];
  assign xneg1  = xm1_q;
  assign y_ext  = {y_q[4], y_q};
  assign operand = (selMux == SEL_ADD_Y) ? y_ext :
                   (selMux == SEL_SUB_Y) ? -y_ext : 6'sd0;

  initial begin
    y_q = '0; x_q = '0; a_q = '0; xm1_q = 1'b0;
  end

  always @(posedge clk) begin
    logic signed [10:0] sh;
    if (LdY) y_q <= inBus;
    if (LdX) x_q <= inBus;
    if (ClrAX) begin
      a_q   <= '0;
      xm1_q <= 1'b0;
    end
    if (LdA) a_q <= a_q + operand;
    if (shR) begin
      sh = $signed({a_q, x_q}) >>> 1;
      a_q <= sh[10:5];
      x_q <= sh[4:0];
      if (LdNegX) xm1_q <= x_q[0];
    end
  end

  // Scoreboard and monitor state.
  logic [9:0] sb_q[$];
  logic [9:0] obs_q[$];
  logic [1:0] sel_log[$];
  logic [4:0] hi_cap;
  int         done_cnt = 0;
  int         viol_cnt = 0;
  int         checks   = 0;
  int         errors   = 0;

  // Collect outBus halves, log ADD selects, and watch protocol invariants.
  always @(negedge clk) begin
    if (selOut) hi_cap = outBus;
    if (done) begin
      obs_q.push_back({hi_cap, outBus});
      done_cnt++;
    end
    if (LdA) sel_log.push_back(selMux);
    assert ($countones({LdY, LdX, LdA, shR}) <= 1)
      else $error("strobes not mutually exclusive");
    assert (busy == (dut.state_q != IDLE))
      else $error("busy does not track IDLE");
    if ($countones({LdY, LdX, LdA, shR}) > 1) viol_cnt++;
    if (busy != (dut.state_q != IDLE)) viol_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end else begin
      check({name, "_latency"}, lat, exp_lat);
    end
  endtask

  task automatic drain(input string name);
    logic [9:0] exp, got;
    #1;
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL %s_product: got nothing expected %0d results", name, sb_q.size());
    end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_product: got %0h expected no result", name, got);
      end else begin
        exp = sb_q.pop_front();
        check({name, "_product"}, {22'd0, got}, {22'd0, exp});
      end
    end
  endtask

  task automatic run_op(input logic [4:0] y, input logic [4:0] x, input logic [9:0] exp,
                        input string name);
    y_cur = y;
    x_cur = x;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(name, 14);
    drain(name);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"},   busy, 0);
    check({name, "_done"},   done, 0);
    check({name, "_selMux"}, selMux, 2'b10);
    check({name, "_strobes"}, {LdY, LdX, ClrAX, LdA, shR, LdNegX, selOut}, 0);
  endtask

  typedef struct packed {
    logic [4:0] y;
    logic [4:0] x;
    logic [4:0] hi;
    logic [4:0] lo;
  } vec_t;

  vec_t       vecs[7];
  logic [1:0] exp_sel[5];

  initial begin
    int         base;
    int         p;
    logic [4:0] ry, rx;
    logic [9:0] pv;

    vecs[0] = '{y: 5'd5,      x: 5'd3,      hi: 5'b00000, lo: 5'b01111};
    vecs[1] = '{y: 5'd5,      x: 5'b11101,  hi: 5'b11111, lo: 5'b10001};
    vecs[2] = '{y: 5'b10000,  x: 5'b10000,  hi: 5'b01000, lo: 5'b00000};
    vecs[3] = '{y: 5'd7,      x: 5'd0,      hi: 5'b00000, lo: 5'b00000};
    vecs[4] = '{y: 5'd15,     x: 5'd15,     hi: 5'b00111, lo: 5'b00001};
    vecs[5] = '{y: 5'b10000,  x: 5'd15,     hi: 5'b11000, lo: 5'b10000};
    vecs[6] = '{y: 5'b11111,  x: 5'b11111,  hi: 5'b00000, lo: 5'b00001};
    exp_sel = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b10};

    rst   = 1'b0;
    start = 1'b0;
    y_cur = '0;
    x_cur = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");

    // 5 * 3 with the ADD select sequence.
    sel_log.delete();
    run_op(5'd5, 5'd3, 10'd15, "y5x3");
    check("y5x3_sel_count", sel_log.size(), 5);
    for (int i = 0; i < 5 && i < sel_log.size(); i++) begin
      check($sformatf("y5x3_sel%0d", i), sel_log[i], exp_sel[i]);
    end

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].y, vecs[i].x, {vecs[i].hi, vecs[i].lo}, $sformatf("vec%0d", i));
    end

    // start re-pulsed during ADD is ignored.
    base  = done_cnt;
    y_cur = 5'd6;
    x_cur = 5'b11110;
    sb_q.push_back(10'b1111110100);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("repulse", 11);
    drain("repulse");
    repeat (20) @(negedge clk);
    check("repulse_done_pulses", done_cnt - base, 1);

    // start held high: back-to-back operations with one IDLE cycle between.
    base  = done_cnt;
    y_cur = 5'd3;
    x_cur = 5'd9;
    sb_q.push_back(10'd27);
    sb_q.push_back(10'd27);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("held1", 14);
    wait_done("held2", 15);
    start = 1'b0;
    drain("held");
    repeat (20) @(negedge clk);
    check("held_done_pulses", done_cnt - base, 2);

    // Asynchronous reset in the third SHIFT cycle.
    base  = done_cnt;
    y_cur = 5'd11;
    x_cur = 5'd13;
    sb_q.push_back(10'd143);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_mid_in_shift", shR, 1);
    #1 rst = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    check("rst_mid_no_done", done_cnt - base, 0);
    run_op(5'd7, 5'd0, 10'd0, "after_rst");

    // Random signed pairs against the 10-bit signed product.
    for (int n = 0; n < 1000; n++) begin
      ry = 5'($urandom_range(0, 31));
      rx = 5'($urandom_range(0, 31));
      p  = int'($signed(ry)) * int'($signed(rx));
      pv = p[9:0];
      run_op(ry, rx, pv, "rand");
    end

    check("protocol_violations", viol_cnt, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
